// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: host command codes and FSM states.
package mem_pkg;

    localparam logic [7:0] CMD_HOLD  = 8'h48;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_RREQ,
        ST_RWAIT,
        ST_RSEND
    } state_e;

endpackage

// File: rtl/ram_bytes.sv
// Byte RAM with one write port and one registered, read-before-write read port.
module ram_bytes #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem [0:(2**addr_width)-1];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register reset is the only reset here; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the cpu byte bus, with a host byte-stream loader that can
// hold the cpu and bulk read/write the RAM.
module mem_responder
    import mem_pkg::*;
#(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] mem_raddr,
    input  logic [addr_width-1:0] mem_waddr,
    input  logic                  mem_write,
    input  logic [7:0]            mem_data_in,
    output logic [7:0]            mem_data_out,
    output logic                  mem_ready,
    output logic                  cpu_hold,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    state_e      state_q, state_d;
    logic [1:0]  hc_q, hc_d;
    logic        hold_q, hold_d;
    logic        is_read_q, is_read_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        host_we;

    logic                  ram_we;
    logic [addr_width-1:0] ram_waddr;
    logic [7:0]            ram_wdata;
    logic [addr_width-1:0] ram_raddr;

    // The host owns both RAM ports while the cpu is held.
    assign ram_raddr = hold_q ? addr_q[addr_width-1:0] : mem_raddr;
    assign ram_we    = hold_q ? host_we : mem_write;
    assign ram_waddr = hold_q ? addr_q[addr_width-1:0] : mem_waddr;
    assign ram_wdata = hold_q ? rx_data : mem_data_in;

    ram_bytes #(.addr_width(addr_width)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (mem_data_out)
    );

    always_comb begin
        state_d    = state_q;
        hc_d       = hc_q;
        hold_d     = hold_q;
        is_read_d  = is_read_q;
        addr_d     = addr_q;
        len_d      = len_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        host_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_HOLD:  hold_d = 1'b1;
                        CMD_GO:    hold_d = 1'b0;
                        CMD_WRITE: begin
                            state_d   = ST_HDR;
                            hc_d      = 2'd0;
                            is_read_d = 1'b0;
                        end
                        CMD_READ: begin
                            state_d   = ST_HDR;
                            hc_d      = 2'd0;
                            is_read_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HDR: begin
                if (rx_valid) begin
                    hc_d = hc_q + 2'd1;
                    case (hc_q)
                        2'd0: addr_d[15:8] = rx_data;
                        2'd1: addr_d[7:0]  = rx_data;
                        2'd2: len_d[15:8]  = rx_data;
                        default: begin
                            len_d[7:0] = rx_data;
                            if ({len_q[15:8], rx_data} == 16'd0) begin
                                state_d = ST_IDLE;
                            end else if (is_read_q) begin
                                state_d = ST_RREQ;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    endcase
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    host_we = hold_q;
                    addr_d  = addr_q + 16'd1;
                    len_d   = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RREQ: begin
                state_d = hold_q ? ST_RWAIT : ST_IDLE;
            end
            ST_RWAIT: begin
                // The read issued in RREQ is on mem_data_out now.
                tx_data_d  = mem_data_out;
                tx_valid_d = 1'b1;
                state_d    = ST_RSEND;
            end
            ST_RSEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 16'd1;
                    len_d      = len_q - 16'd1;
                    state_d    = (len_q == 16'd1) ? ST_IDLE : ST_RREQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hc_q       <= 2'd0;
            hold_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hc_q       <= hc_d;
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        is_read_q <= is_read_d;
        addr_q    <= addr_d;
        len_q     <= len_d;
    end

    assign cpu_hold  = hold_q;
    assign mem_ready = ~hold_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;

endmodule
